// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control slices: state encodings,
// control-word layout, datapath select codes and opcode constants.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXEC    = 2'b01,
        ST_WB      = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    localparam int CW_WIDTH  = 31;
    localparam int REG_W     = 5;
    localparam int FS_W      = 5;
    localparam int DSEL_W    = 2;
    localparam int PS_W      = 2;

    localparam int DA_LSB    = 26;
    localparam int SA_LSB    = 21;
    localparam int SB_LSB    = 16;
    localparam int FS_LSB    = 11;
    localparam int C0_BIT    = 10;
    localparam int BSEL_BIT  = 9;
    localparam int REGW_BIT  = 8;
    localparam int MEMW_BIT  = 7;
    localparam int MEMR_BIT  = 6;
    localparam int DSEL_LSB  = 4;
    localparam int PS_LSB    = 2;
    localparam int IRL_BIT   = 1;
    localparam int STL_BIT   = 0;

    localparam logic [FS_W-1:0]   FS_ADD    = 5'b01000;
    localparam logic [FS_W-1:0]   FS_PASS_A = 5'b00000;

    localparam logic [PS_W-1:0]   PS_HOLD   = 2'b00;
    localparam logic [PS_W-1:0]   PS_INC    = 2'b01;
    localparam logic [PS_W-1:0]   PS_BRANCH = 2'b10;
    localparam logic [PS_W-1:0]   PS_REG    = 2'b11;

    localparam logic [DSEL_W-1:0] DSEL_ALU  = 2'b00;
    localparam logic [DSEL_W-1:0] DSEL_RAM  = 2'b01;
    localparam logic [DSEL_W-1:0] DSEL_PC4  = 2'b10;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;
    localparam logic [5:0]  OP_BL   = 6'b100101;

    localparam logic [REG_W-1:0] LINK_REG = 5'd30;

    typedef struct packed {
        logic [REG_W-1:0]  da;
        logic [REG_W-1:0]  sa;
        logic [REG_W-1:0]  sb;
        logic [FS_W-1:0]   fs;
        logic              c0;
        logic              bsel;
        logic              reg_write;
        logic              mem_write;
        logic              mem_read;
        logic [DSEL_W-1:0] data_sel;
        logic [PS_W-1:0]   ps;
        logic              ir_load;
        logic              status_load;
    } ctrl_fields_t;

    localparam ctrl_fields_t CTRL_ZERO = '0;

endpackage

// File: rtl/ctrl_word_pack.sv
// Packs the named control fields into the 31-bit datapath control word using
// the shared field offsets, so the layout is defined in exactly one place.
module ctrl_word_pack
    import cpu_ctrl_pkg::*;
(
    input  ctrl_fields_t              fields,
    output logic [CW_WIDTH-1:0]       controlword
);

    always_comb begin
        controlword = '0;
        controlword[DA_LSB   +: REG_W]  = fields.da;
        controlword[SA_LSB   +: REG_W]  = fields.sa;
        controlword[SB_LSB   +: REG_W]  = fields.sb;
        controlword[FS_LSB   +: FS_W]   = fields.fs;
        controlword[C0_BIT]             = fields.c0;
        controlword[BSEL_BIT]           = fields.bsel;
        controlword[REGW_BIT]           = fields.reg_write;
        controlword[MEMW_BIT]           = fields.mem_write;
        controlword[MEMR_BIT]           = fields.mem_read;
        controlword[DSEL_LSB +: DSEL_W] = fields.data_sel;
        controlword[PS_LSB   +: PS_W]   = fields.ps;
        controlword[IRL_BIT]            = fields.ir_load;
        controlword[STL_BIT]            = fields.status_load;
    end

endmodule

// File: rtl/bl_br_d_control.sv
// Multi-cycle LEGv8 control slice for LDUR/STUR, BL and BR: a 2-bit state
// register plus combinational decode of the control word and constant.
module bl_br_d_control
    import cpu_ctrl_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         instruction,
    input  logic [4:0]          status,
    output logic [CW_WIDTH-1:0] controlword,
    output logic [63:0]         constant,
    output logic [1:0]          state
);

    state_t       state_reg;
    state_t       state_next;
    ctrl_fields_t fields;

    // Status flags play no part in these instructions.
    logic unused_status;
    assign unused_status = ^status;

    logic is_ldur;
    logic is_stur;
    logic is_bl;
    logic is_br;

    assign is_ldur = (instruction[31:21] == OP_LDUR);
    assign is_stur = (instruction[31:21] == OP_STUR);
    assign is_bl   = (instruction[31:26] == OP_BL);
    assign is_br   = (instruction[31:21] == OP_BR);

    function automatic ctrl_fields_t d_format_fields(input logic [31:0] ir, input state_t st);
        ctrl_fields_t f;
        f      = CTRL_ZERO;
        f.sa   = ir[9:5];
        f.bsel = 1'b1;
        f.fs   = FS_ADD;
        if (ir[31:21] == OP_STUR) begin
            f.sb        = ir[4:0];
            f.mem_write = 1'b1;
            f.ps        = PS_INC;
        end else begin
            // The load address stays on the bus through WB so RAM data holds.
            f.mem_read = 1'b1;
            if (st == ST_WB) begin
                f.da        = ir[4:0];
                f.reg_write = 1'b1;
                f.data_sel  = DSEL_RAM;
                f.ps        = PS_INC;
            end
        end
        return f;
    endfunction

    function automatic ctrl_fields_t bl_fields();
        ctrl_fields_t f;
        f           = CTRL_ZERO;
        f.da        = LINK_REG;
        f.reg_write = 1'b1;
        f.data_sel  = DSEL_PC4;
        f.ps        = PS_BRANCH;
        return f;
    endfunction

    function automatic ctrl_fields_t br_fields(input logic [31:0] ir);
        ctrl_fields_t f;
        f    = CTRL_ZERO;
        f.sa = ir[9:5];
        f.fs = FS_PASS_A;
        f.ps = PS_REG;
        return f;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        fields     = CTRL_ZERO;
        constant   = '0;
        state_next = ST_FETCH;
        case (state_reg)
            ST_FETCH: begin
                fields.ir_load = 1'b1;
                state_next     = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_ldur || is_stur) begin
                    fields   = d_format_fields(instruction, state_reg);
                    constant = {{55{instruction[20]}}, instruction[20:12]};
                    if (is_ldur) begin
                        state_next = ST_WB;
                    end
                end else if (is_bl) begin
                    fields   = bl_fields();
                    constant = {{38{instruction[25]}}, instruction[25:0]};
                end else if (is_br) begin
                    fields = br_fields(instruction);
                end
            end
            ST_WB: begin
                if (is_ldur) begin
                    fields   = d_format_fields(instruction, state_reg);
                    constant = {{55{instruction[20]}}, instruction[20:12]};
                end
            end
            default: begin
            end
        endcase
    end

    ctrl_word_pack u_pack (
        .fields      (fields),
        .controlword (controlword)
    );

    assign state = state_reg;

endmodule

// File: tb/tb_bl_br_d_control.sv
// Randomized self-checking bench for bl_br_d_control against a per-instruction
// reference model of the expected cycle sequence.
module tb_bl_br_d_control;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = '0;
    logic [4:0]  status = '0;
    logic [30:0] controlword;
    logic [63:0] constant;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    typedef enum {K_LDUR, K_STUR, K_BL, K_BR, K_NONE} kind_e;

    bl_br_d_control dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .status      (status),
        .controlword (controlword),
        .constant    (constant),
        .state       (state)
    );

    always #50 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic kind_e classify(input logic [31:0] ir);
        logic [10:0] op11;
        logic [5:0]  op6;
        op11 = ir[31:21];
        op6  = ir[31:26];
        if (op11 == 11'h7C2) return K_LDUR;
        if (op11 == 11'h7C0) return K_STUR;
        if (op11 == 11'h6B0) return K_BR;
        if (op6 == 6'h25)    return K_BL;
        return K_NONE;
    endfunction

    // Expected control word assembled arithmetically from its field values.
    function automatic logic [63:0] cw(input longint da, sa, sb, fs, bsel, rw, mw, mr, dsel, ps, irl);
        longint v;
        v = da * 67108864 + sa * 2097152 + sb * 65536 + fs * 2048
          + bsel * 512 + rw * 256 + mw * 128 + mr * 64 + dsel * 16 + ps * 4 + irl * 2;
        return 64'(v);
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
        status = 5'($urandom);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] ir, input string tag, input bit sweep, input bit abort);
        kind_e  k;
        longint rn;
        longint rt;
        longint imm9;
        longint imm26;
        k     = classify(ir);
        rn    = longint'(ir[9:5]);
        rt    = longint'(ir[4:0]);
        imm9  = longint'(ir[20:12]);
        if (imm9 >= 256) imm9 -= 512;
        imm26 = longint'(ir[25:0]);
        if (imm26 >= 33554432) imm26 -= 67108864;

        instruction = ir;
        status = 5'($urandom);
        #1;
        $display("instr %s ir=0x%08h kind=%s", tag, ir, k.name());
        chk({tag, " fetch state"}, 64'(state), 64'd0);
        chk({tag, " fetch cw"}, 64'(controlword), cw(0,0,0,0,0,0,0,0,0,0,1));

        next_cycle();
        chk({tag, " exec state"}, 64'(state), 64'd1);
        case (k)
            K_LDUR: begin
                chk({tag, " exec cw"}, 64'(controlword), cw(0,rn,0,8,1,0,0,1,0,0,0));
                chk({tag, " exec const"}, constant, 64'(imm9));
            end
            K_STUR: begin
                chk({tag, " exec cw"}, 64'(controlword), cw(0,rn,rt,8,1,0,1,0,0,1,0));
                chk({tag, " exec const"}, constant, 64'(imm9));
            end
            K_BL: begin
                chk({tag, " exec cw"}, 64'(controlword), cw(30,0,0,0,0,1,0,0,2,2,0));
                chk({tag, " exec const"}, constant, 64'(imm26));
            end
            K_BR: begin
                chk({tag, " exec cw"}, 64'(controlword), cw(0,rn,0,0,0,0,0,0,0,3,0));
                chk({tag, " exec const"}, constant, 64'd0);
            end
            default: begin
                chk({tag, " exec cw"}, 64'(controlword), 64'd0);
                chk({tag, " exec const"}, constant, 64'd0);
            end
        endcase

        if (sweep) begin
            for (int s = 0; s < 32; s++) begin
                status = 5'(s);
                #1;
                chk($sformatf("%s status=%0d cw", tag, s), 64'(controlword), 64'd0);
                chk($sformatf("%s status=%0d const", tag, s), constant, 64'd0);
            end
        end

        if (abort) begin
            #2;
            reset = 1'b1;
            #1;
            chk({tag, " abort state"}, 64'(state), 64'd0);
            chk({tag, " abort cw"}, 64'(controlword), cw(0,0,0,0,0,0,0,0,0,0,1));
            #1;
            reset = 1'b0;
            return;
        end

        if (k == K_LDUR) begin
            next_cycle();
            chk({tag, " wb state"}, 64'(state), 64'd2);
            chk({tag, " wb cw"}, 64'(controlword), cw(rt,rn,0,8,1,1,0,1,1,1,0));
            chk({tag, " wb const"}, constant, 64'(imm9));
        end

        next_cycle();
        chk({tag, " return state"}, 64'(state), 64'd0);
    endtask

    initial begin
        logic [31:0] ir;
        int          r;

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset state", 64'(state), 64'd0);
        chk("reset cw", 64'(controlword), cw(0,0,0,0,0,0,0,0,0,0,1));
        @(negedge clock);
        reset = 1'b0;

        run_instr(32'hF81F8062, "stur_dir", 1'b0, 1'b0);
        run_instr(32'hF8410025, "ldur_dir", 1'b0, 1'b0);
        run_instr(32'h97FFFFFF, "bl_dir", 1'b0, 1'b0);
        run_instr(32'hD61F00E0, "br_dir", 1'b0, 1'b0);
        run_instr(32'hF8410025, "ldur_abort", 1'b0, 1'b1);
        run_instr(32'h00000000, "unknown_dir", 1'b1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 4));
            case (r)
                0: ir = {11'h7C2, 21'($urandom)};
                1: ir = {11'h7C0, 21'($urandom)};
                2: ir = {6'h25, 26'($urandom)};
                3: ir = {11'h6B0, 21'($urandom)};
                default: begin
                    ir = $urandom;
                    while (classify(ir) != K_NONE) ir = $urandom;
                end
            endcase
            run_instr(ir, $sformatf("rnd%0d", i), 1'b0, (i % 17) == 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
